// File: rtl/mv_median_filter_pkg.sv
// Shared definitions for the motion-vector median filter: state encoding,
// default field geometry, vector field positions and the signed component type.
package mv_median_filter_pkg;

    localparam int BLK_W_DEF = 134;
    localparam int BLK_H_DEF = 60;

    localparam int VEC_W = 14;
    localparam int Y_MSB = 13;
    localparam int Y_LSB = 7;
    localparam int X_MSB = 6;
    localparam int X_LSB = 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_CALC   = 3'd2;
    localparam logic [2:0] ST_OUTPUT = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    typedef logic signed [6:0] comp_t;

endpackage

// File: rtl/mv_median_filter_if.sv
// Control, vector-memory read port and output stream of the median filter.
interface mv_median_filter_if #(
    parameter int AW = 14
);
    import mv_median_filter_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        rd_addr;
    logic [VEC_W-1:0]     rd_vec;
    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        out_addr;
    logic [VEC_W-1:0]     out_vec;

    modport master (
        output start, rd_vec, out_ready,
        input  busy, done, rd_addr, out_valid, out_addr, out_vec
    );

    modport slave (
        input  start, rd_vec, out_ready,
        output busy, done, rd_addr, out_valid, out_addr, out_vec
    );

endinterface

// File: rtl/mv_median_filter_median5_s7.sv
// Exact median of five signed 7-bit values, taken from a pruned
// nine-comparator sorting network (only the paths feeding rank 2 are kept).
module median5_s7
    import mv_median_filter_pkg::*;
(
    input  comp_t a0_i,
    input  comp_t a1_i,
    input  comp_t a2_i,
    input  comp_t a3_i,
    input  comp_t a4_i,
    output comp_t med_o
);

    function automatic comp_t smin(input comp_t a, input comp_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic comp_t smax(input comp_t a, input comp_t b);
        return (a < b) ? b : a;
    endfunction

    comp_t v0_s, v1_s, v3_s, v4_s;
    comp_t v2a_s, v4a_s, v2b_s, v3a_s, v1a_s, v0a_s, v3b_s, v2c_s, v1b_s;

    assign v0_s  = smin(a0_i, a1_i);
    assign v1_s  = smax(a0_i, a1_i);
    assign v3_s  = smin(a3_i, a4_i);
    assign v4_s  = smax(a3_i, a4_i);
    assign v2a_s = smin(a2_i, v4_s);
    assign v4a_s = smax(a2_i, v4_s);
    assign v2b_s = smin(v2a_s, v3_s);
    assign v3a_s = smax(v2a_s, v3_s);
    assign v1a_s = smin(v1_s, v4a_s);
    assign v0a_s = smin(v0_s, v3a_s);
    assign v3b_s = smax(v0_s, v3a_s);
    assign v2c_s = smax(v0a_s, v2b_s);
    assign v1b_s = smin(v1a_s, v3b_s);
    assign med_o = smax(v1b_s, v2c_s);

endmodule

// File: rtl/mv_median_filter.sv
// Raster-order 5-point (centre + 4-neighbour) component-wise median filter over
// a motion-vector field held in an external registered-address memory.
module mv_median_filter
    import mv_median_filter_pkg::*;
#(
    parameter int BLK_W = BLK_W_DEF,
    parameter int BLK_H = BLK_H_DEF,
    parameter int AW    = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    mv_median_filter_if.slave bus
);

    localparam logic [AW-1:0] ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] W_STEP   = AW'(BLK_W);
    localparam logic [AW-1:0] COL_LAST = AW'(BLK_W - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(BLK_H - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(BLK_W * BLK_H - 1);

    logic [2:0]       state_q, state_d, step_q, step_d, cap_k_s, nxt_k_s;
    logic [AW-1:0]    idx_q, idx_d, row_q, row_d, col_q, col_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d, out_addr_q, out_addr_d;
    logic [VEC_W-1:0] vec_q [5];
    logic [VEC_W-1:0] vec_d [5];
    logic [VEC_W-1:0] out_vec_q, out_vec_d;
    logic             out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
    comp_t            x_s [5];
    comp_t            y_s [5];
    comp_t            med_x_s, med_y_s;

    // Slot k: 1 left, 2 right, 3 up, 4 down; true when that neighbour is off-frame.
    function automatic logic nb_out(input logic [2:0] k, input logic [AW-1:0] row,
                                    input logic [AW-1:0] col);
        case (k)
            3'd1:    return col == ZERO;
            3'd2:    return col == COL_LAST;
            3'd3:    return row == ZERO;
            3'd4:    return row == ROW_LAST;
            default: return 1'b0;
        endcase
    endfunction

    // Off-frame neighbours fall back to the centre address so reads stay in range.
    function automatic logic [AW-1:0] nb_addr(input logic [2:0] k, input logic [AW-1:0] a,
                                              input logic oob);
        logic [AW-1:0] r;
        r = a;
        if (!oob) begin
            case (k)
                3'd1:    r = a - ONE;
                3'd2:    r = a + ONE;
                3'd3:    r = a - W_STEP;
                3'd4:    r = a + W_STEP;
                default: r = a;
            endcase
        end else begin
            r = a;
        end
        return r;
    endfunction

    // Split the captured vectors into signed components for the two medians.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            x_s[i] = comp_t'(vec_q[i][X_MSB:X_LSB]);
            y_s[i] = comp_t'(vec_q[i][Y_MSB:Y_LSB]);
        end
    end

    median5_s7 u_med_x (.a0_i(x_s[0]), .a1_i(x_s[1]), .a2_i(x_s[2]), .a3_i(x_s[3]),
                        .a4_i(x_s[4]), .med_o(med_x_s));
    median5_s7 u_med_y (.a0_i(y_s[0]), .a1_i(y_s[1]), .a2_i(y_s[2]), .a3_i(y_s[3]),
                        .a4_i(y_s[4]), .med_o(med_y_s));

    // Next-state logic for the fetch / median / handshake sequence.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_addr_d   = rd_addr_q;
        out_addr_d  = out_addr_q;
        out_vec_d   = out_vec_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        vec_d       = vec_q;
        cap_k_s     = step_q - 3'd1;
        nxt_k_s     = step_q + 3'd1;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_FETCH;
                    step_d    = 3'd0;
                    idx_d     = ZERO;
                    row_d     = ZERO;
                    col_d     = ZERO;
                    rd_addr_d = ZERO;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (step_q < 3'd4) begin
                    rd_addr_d = nb_addr(nxt_k_s, idx_q, nb_out(nxt_k_s, row_q, col_q));
                end else begin
                    rd_addr_d = rd_addr_q;
                end
                // Data for the address issued at step k-1 arrives at step k.
                if (step_q != 3'd0) begin
                    if (nb_out(cap_k_s, row_q, col_q)) begin
                        vec_d[cap_k_s] = vec_q[0];
                    end else begin
                        vec_d[cap_k_s] = bus.rd_vec;
                    end
                end else begin
                    vec_d = vec_q;
                end
                if (step_q == 3'd5) begin
                    state_d = ST_CALC;
                    step_d  = 3'd0;
                end else begin
                    step_d = nxt_k_s;
                end
            end
            ST_CALC: begin
                out_vec_d   = {med_y_s, med_x_s};
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_FETCH;
                        step_d    = 3'd0;
                        idx_d     = idx_q + ONE;
                        rd_addr_d = idx_q + ONE;
                        if (col_q == COL_LAST) begin
                            col_d = ZERO;
                            row_d = row_q + ONE;
                        end else begin
                            col_d = col_q + ONE;
                        end
                    end
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 3'd0;
            idx_q       <= ZERO;
            row_q       <= ZERO;
            col_q       <= ZERO;
            rd_addr_q   <= ZERO;
            out_addr_q  <= ZERO;
            out_vec_q   <= {VEC_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_q       <= '{default: {VEC_W{1'b0}}};
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_addr_q   <= rd_addr_d;
            out_addr_q  <= out_addr_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vec_q       <= vec_d;
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: doc/mv_median_filter.md
MV_MEDIAN_FILTER -- requirements
Module: mv_median_filter

Interface
REQ-001 Parameter BLK_W, default 134, blocks per row of the motion-vector field.
REQ-002 Parameter BLK_H, default 60, block rows per frame (BLK_W*BLK_H = 8040 vector-memory entries).
REQ-003 Parameter AW, default 14, vector-memory address width.
REQ-004 Port clk  input  1  single clock; all state on the rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  one-cycle pulse that begins filtering one frame.
REQ-007 Port busy  output  1  high from the cycle after an accepted start until done.
REQ-008 Port done  output  1  one-cycle pulse after the last filtered vector is accepted.
REQ-009 Port rd_addr  output  AW  read address to the vector memory's second read port.
REQ-010 Port rd_vec  input  14  vector read back; valid one cycle after rd_addr, because the memory registers the address.
REQ-011 Port out_valid  output  1  filtered vector available.
REQ-012 Port out_ready  input  1  consumer accepts the vector when out_valid and out_ready are both high.
REQ-013 Port out_addr  output  AW  raster index of the filtered block.
REQ-014 Port out_vec  output  14  filtered vector: [13:7] vertical, [6:0] horizontal, each 7-bit two's complement.

Function
REQ-015 States SHALL be IDLE, FETCH, CALC, OUTPUT and FIN; start is honoured only in IDLE and ignored otherwise.
REQ-016 Blocks SHALL be processed in raster order, index 0 to BLK_W*BLK_H-1, tracked with row and column counters (no division).
REQ-017 FETCH SHALL drive rd_addr on five consecutive cycles with centre a, left a-1, right a+1, up a-BLK_W and down a+BLK_W, in that order.
REQ-018 Each rd_vec SHALL be captured on the cycle after its address, so FETCH lasts six cycles.
REQ-019 A neighbour outside the frame (column 0 left, column BLK_W-1 right, row 0 up, row BLK_H-1 down) SHALL NOT be read and SHALL be replaced by the centre vector; rd_addr SHALL never leave 0..BLK_W*BLK_H-1.
REQ-020 CALC SHALL take one cycle and compute a component-wise median of the five vectors, comparing each 7-bit component as signed.
REQ-021 The median SHALL be exact: the third-smallest of five, ties included, with no saturation or rounding.
REQ-022 OUTPUT SHALL assert out_valid with out_vec and out_addr held constant until out_ready is high.
REQ-023 After a handshake the block SHALL move to FETCH for the next index, or to FIN after the last index.
REQ-024 FIN SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-025 Under continuous out_ready the throughput SHALL be one vector per 8 cycles (6 FETCH + 1 CALC + 1 OUTPUT).

Reset
REQ-026 While rst_n is low the block SHALL be in IDLE and busy, done, out_valid, rd_addr, out_addr and out_vec SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately: no done pulse and no further out_valid.
REQ-028 After rst_n deasserts, the block SHALL wait in IDLE for a new start.

Structure
REQ-029 The shared package SHALL hold the state encoding, the BLK_W/BLK_H defaults, the field bit positions [13:7]/[6:0] and a 7-bit signed component typedef.
REQ-030 The median SHALL be a sub-module, median5_s7: a purely combinational sorting network instantiated twice, once per component.

Verification
REQ-031 All-zero memory, start, out_ready=1 -> 8040 handshakes, out_addr 0..8039 in order, every out_vec=14'h0, a single done, busy low afterwards.
REQ-032 Block at row 5, col 5: centre (x=10,y=10), four neighbours (0,0) -> out_vec=(0,0).
REQ-033 Block 0: centre (x=5,y=-3), i.e. y field 7'h7D; right and down (0,0) -> out_vec=(5,-3) and no read outside 0..8039.
REQ-034 Mixed signs: five horizontal values -36,-1,0,1,36 (vertical 0) -> x=0; five vertical values -3,-3,2,5,5 -> y=2.
REQ-035 out_ready held low for 10 cycles in OUTPUT -> out_valid stays high, out_vec/out_addr stable, rd_addr does not advance; on release exactly one handshake.
REQ-036 rst_n pulsed low at block 100 -> all outputs 0 immediately, no done pulse; a new start then filters from index 0.
